// File: rtl/trace_pkg.sv
// trace_pkg: shared state encoding, default core widths and entry field offsets for the trace buffer
package trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, READ = 2'd3} state_t;
  localparam int TR_DATA_W   = 16;
  localparam int TR_PC_W     = 6;
  localparam int TR_OP_W     = 5;
  localparam int TR_ZERO_LSB = 0;
  localparam int TR_ALU_LSB  = 1;
  localparam int TR_OP_LSB   = TR_ALU_LSB + TR_DATA_W;
  localparam int TR_PC_LSB   = TR_OP_LSB + TR_OP_W;
  localparam int TR_E        = TR_PC_LSB + TR_PC_W;
endpackage

// File: rtl/trace_ram.sv
// trace_ram: flop array with one synchronous write port and one combinational read port
module trace_ram #(
  parameter int DEPTH = 32,
  parameter int E     = 28
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [E-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [E-1:0]             o_rdata
);
  logic [E-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/trace_capture.sv
// trace_capture: PC-triggered circular trace buffer that freezes on capture and streams oldest-first
module trace_capture
  import trace_pkg::*;
#(
  parameter int DATA_W   = TR_DATA_W,
  parameter int PC_W     = TR_PC_W,
  parameter int OP_W     = TR_OP_W,
  parameter int DEPTH    = 32,
  parameter int PRE_TRIG = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_arm,
  input  logic                        i_abort,
  input  logic                        i_trig_en,
  input  logic [PC_W-1:0]             i_trig_pc,
  input  logic                        i_s_valid,
  input  logic [PC_W-1:0]             i_s_pc,
  input  logic [OP_W-1:0]             i_s_op,
  input  logic [DATA_W-1:0]           i_s_alu,
  input  logic                        i_s_zero,
  input  logic                        i_rd_ready,
  output logic                        o_rd_valid,
  output logic [PC_W+OP_W+DATA_W:0]   o_rd_data,
  output logic                        o_rd_last,
  output logic [1:0]                  o_state,
  output logic [$clog2(DEPTH):0]      o_fill
);
  localparam int E      = PC_W + OP_W + DATA_W + 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int POST_N = DEPTH - PRE_TRIG - 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  state_t          r_state, w_nxt;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr, r_post_cnt, w_wr_nxt;
  logic [AW:0]     r_fill, r_rem, w_fill_nxt;
  logic [E-1:0]    w_rdata;
  logic            w_cap, w_hit;
  assign w_cap      = (r_state == ARMED || r_state == POST) && i_s_valid && !i_abort;
  assign w_hit      = w_cap && r_state == ARMED && i_trig_en && i_s_pc == i_trig_pc;
  assign w_wr_nxt   = r_wr_ptr + AW'(1);
  assign w_fill_nxt = (r_fill == FULL) ? r_fill : r_fill + ONE;
  trace_ram #(.DEPTH(DEPTH), .E(E)) u_ram (
    .clk     (clk),
    .i_we    (w_cap),
    .i_waddr (r_wr_ptr),
    .i_wdata ({i_s_pc, i_s_op, i_s_alu, i_s_zero}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:  w_nxt = i_arm ? ARMED : IDLE;
      ARMED: w_nxt = w_hit ? ((POST_N == 0) ? READ : POST) : ARMED;
      POST:  w_nxt = (w_cap && r_post_cnt == AW'(1)) ? READ : POST;
      READ:  w_nxt = (i_rd_ready && r_rem == ONE) ? IDLE : READ;
    endcase
    if (i_abort) w_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  // READ is only ever entered on a capture write, so the post-write pointer/fill give the oldest entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_post_cnt <= '0;
      r_fill     <= '0;
      r_rem      <= '0;
    end else if (i_abort) begin
      r_fill <= '0;
      r_rem  <= '0;
    end else begin
      if (r_state == IDLE && i_arm) begin
        r_wr_ptr <= '0;
        r_fill   <= '0;
      end
      if (w_cap) begin
        r_wr_ptr <= w_wr_nxt;
        r_fill   <= w_fill_nxt;
      end
      if (w_hit) r_post_cnt <= AW'(POST_N);
      else if (w_cap && r_state == POST) r_post_cnt <= r_post_cnt - AW'(1);
      if (w_nxt == READ && r_state != READ) begin
        r_rd_ptr <= w_wr_nxt - w_fill_nxt[AW-1:0];
        r_rem    <= w_fill_nxt;
      end
      if (r_state == READ && i_rd_ready) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_rem    <= r_rem - ONE;
        if (r_rem == ONE) r_fill <= '0;
      end
    end
  assign o_rd_valid = r_state == READ;
  assign o_rd_data  = o_rd_valid ? w_rdata : '0;
  assign o_rd_last  = o_rd_valid && r_rem == ONE;
  assign o_state    = r_state;
  assign o_fill     = r_fill;
endmodule
